opcode_sequencer: RTL and testbench
===================================

// Module: opcode_sequencer
// PURPOSE
//  Registered, parametrised successor to the combinational opcode decoder. Accepts instruction
//  words over a valid/ready handshake, splits opcode/operand and drives a registered one-hot op
//  strobe. Sequences multi-cycle ops (EXEC->EXEC2) and latches HALT until resumed.
//  Sits between instruction fetch and datapath control; also counts retired instructions.
// PARAMETERS
//  OPW      4       opcode width; one-hot output width is 2**OPW
//  OPRW     4       operand width; instr = {opcode, operand}
//  MULTI    16'h0006 bitmask, bit k=1 -> opcode k is two-phase (default LD=1, ST=2)
//  HALT_OP  15      opcode that halts the sequencer (END)
//  CNTW     16      retired-instruction counter width
// PORTS
//  clk          in   1         rising-edge clock
//  rst_n        in   1         synchronous active-low reset
//  instr_valid  in   1         instr present
//  instr_ready  out  1         sequencer accepts instr this cycle
//  instr        in   OPW+OPRW  {opcode[OPW+OPRW-1:OPRW], operand[OPRW-1:0]}
//  stall        in   1         datapath busy; hold current phase
//  resume       in   1         leave HALTED
//  op_valid     out  1         op_onehot/operand valid this cycle
//  op_onehot    out  2**OPW    one-hot decoded opcode, all-zero when op_valid=0
//  operand      out  OPRW      registered operand of current instr
//  phase        out  1         0 = first/only phase, 1 = second phase of MULTI op
//  halted       out  1         sequencer in HALTED
//  retired      out  CNTW      saturating count of completed instructions
// BEHAVIOUR
//  - Sync reset (rst_n=0 at edge): state=IDLE; op_valid=0, op_onehot=0, operand=0, phase=0,
//    halted=0, retired=0. Reset mid-op aborts op; it is not counted.
//  - States: IDLE, EXEC, EXEC2, HALTED.
//  - instr_ready = IDLE | (EXEC & !stall & !MULTI[op] & op!=HALT_OP) | (EXEC2 & !stall).
//    Never ready in HALTED. Accept = instr_valid & instr_ready.
//  - Accept at edge N -> EXEC in cycle N+1: op_valid=1, op_onehot=1<<opcode, phase=0.
//    Latency 1 cycle. Back-to-back single-phase ops: 1 instr/cycle.
//  - EXEC & stall: hold all outputs unchanged.
//  - EXEC & !stall: MULTI[op] -> EXEC2 (phase=1, onehot held); op==HALT_OP -> HALTED;
//    else retire; if accept -> EXEC with new instr, else IDLE.
//  - EXEC2 & !stall: retire; accept -> EXEC, else IDLE. EXEC2 & stall: hold.
//  - HALT_OP: one-cycle op_valid strobe in EXEC (not stall-extended beyond stall), then
//    HALTED: halted=1, op_valid=0, retired incremented once on the EXEC->HALTED transition.
//    HALT_OP present in MULTI is ignored (HALT is always single-phase).
//  - HALTED & resume -> IDLE next cycle (halted=0). resume ignored in other states.
//  - op_valid=0 in IDLE/HALTED; op_onehot=0 then; operand holds last value.
//  - retired: +1 per retire edge, saturates at 2**CNTW-1 (no wrap).
//  - instr_valid while not ready: no capture, no state effect; source must hold.
//  - Opcode 0 (NOOP) is a normal single-phase op: strobes bit 0 and retires.
// TESTING
//  1 Reset: rst_n=0 two cycles with instr_valid=1 -> all outputs 0, instr_ready=0 during reset,
//    1 after release, state IDLE.
//  2 Back-to-back: instr 0x35,0xC2,0xE7 on consecutive cycles, stall=0 -> op_onehot 0x0008,
//    0x1000,0x4000 on cycles 1,2,3; operand 5,2,7; instr_ready stays 1; retired=3.
//  3 Multi-phase: instr 0x1A (LD) -> EXEC phase=0 onehot 0x0002, then EXEC2 phase=1 same
//    onehot; instr_ready=0 in EXEC, 1 in EXEC2; retired +1 only after EXEC2.
//  4 Stall: ST 0x23 with stall=1 for 3 cycles in EXEC then EXEC2 -> outputs frozen each
//    stall cycle; total op_valid cycles = 2+stall cycles; single retire.
//  5 Halt: instr 0xF0 -> one op_valid with onehot 0x8000, then halted=1, instr_ready=0 with
//    instr_valid=1 for 5 cycles (nothing taken); resume=1 -> IDLE, next instr accepted.
//  6 Saturation: CNTW=2, issue 5 NOOPs (0x00) -> retired 1,2,3,3,3.

Source files
------------

// File: rtl/opcode_sequencer.sv
// Registered opcode sequencer: accepts {opcode, operand} over valid/ready, drives a one-hot op
// strobe, sequences two-phase ops, latches HALT until resumed and counts retired instructions.
module opcode_sequencer #(
   parameter int unsigned        OPW     = 4,
   parameter int unsigned        OPRW    = 4,
   parameter logic [2**OPW-1:0]  MULTI   = 'h0006,
   parameter int unsigned        HALT_OP = 15,
   parameter int unsigned        CNTW    = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 instr_valid,
   output logic                 instr_ready,
   input  logic [OPW+OPRW-1:0]  instr,
   input  logic                 stall,
   input  logic                 resume,
   output logic                 op_valid,
   output logic [2**OPW-1:0]    op_onehot,
   output logic [OPRW-1:0]      operand,
   output logic                 phase,
   output logic                 halted,
   output logic [CNTW-1:0]      retired
);

   localparam int unsigned NOPS = 2**OPW;

   typedef enum logic [1:0] {StIdle, StExec, StExec2, StHalted} state_e;

   state_e            state_q, state_d;
   logic [OPW-1:0]    opcode_q, opcode_d;
   logic [OPRW-1:0]   operand_q, operand_d;
   logic [CNTW-1:0]   retired_q, retired_d;

   logic is_halt, is_multi, ready_c, accept, retire, load;

   assign is_halt  = (opcode_q == OPW'(HALT_OP));
   // HALT is always single-phase even if its bit is set in MULTI.
   assign is_multi = MULTI[opcode_q] & ~is_halt;

   always_comb begin
      ready_c = 1'b0;
      unique case (state_q)
         StIdle:   ready_c = 1'b1;
         StExec:   ready_c = ~stall & ~is_multi & ~is_halt;
         StExec2:  ready_c = ~stall;
         StHalted: ready_c = 1'b0;
      endcase
   end

   assign instr_ready = rst_n & ready_c;
   assign accept      = instr_valid & instr_ready;

   always_comb begin
      state_d   = state_q;
      opcode_d  = opcode_q;
      operand_d = operand_q;
      retire    = 1'b0;
      load      = 1'b0;
      unique case (state_q)
         StIdle: begin
            load = accept;
         end
         StExec: begin
            if (!stall) begin
               if (is_multi) begin
                  state_d = StExec2;
               end else if (is_halt) begin
                  state_d = StHalted;
                  retire  = 1'b1;
               end else begin
                  state_d = StIdle;
                  retire  = 1'b1;
                  load    = accept;
               end
            end
         end
         StExec2: begin
            if (!stall) begin
               state_d = StIdle;
               retire  = 1'b1;
               load    = accept;
            end
         end
         StHalted: begin
            if (resume) state_d = StIdle;
         end
      endcase
      if (load) begin
         state_d   = StExec;
         opcode_d  = instr[OPW+OPRW-1:OPRW];
         operand_d = instr[OPRW-1:0];
      end
   end

   always_comb begin
      retired_d = retired_q;
      if (retire && (retired_q != {CNTW{1'b1}})) retired_d = retired_q + CNTW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         opcode_q  <= '0;
         operand_q <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         opcode_q  <= opcode_d;
         operand_q <= operand_d;
         retired_q <= retired_d;
      end
   end

   assign op_valid  = (state_q == StExec) || (state_q == StExec2);
   assign op_onehot = op_valid ? (NOPS'(1) << opcode_q) : '0;
   assign operand   = operand_q;
   assign phase     = (state_q == StExec2);
   assign halted    = (state_q == StHalted);
   assign retired   = retired_q;

endmodule

// File: tb/tb_opcode_sequencer.sv
// Bench for opcode_sequencer: directed scenarios then random traffic, all cycles compared
// against a phase-count reference model; a CNTW=2 instance shares the inputs for saturation.
module tb_opcode_sequencer;

   logic        clk = 1'b0;
   logic        rst_n, instr_valid, stall, resume;
   logic [7:0]  instr;
   logic        instr_ready, op_valid, phase, halted;
   logic [15:0] op_onehot, retired;
   logic [3:0]  operand;
   logic        s_ready, s_op_valid, s_phase, s_halted;
   logic [15:0] s_onehot;
   logic [3:0]  s_operand;
   logic [1:0]  s_retired;

   always #5 clk = ~clk;

   opcode_sequencer u_dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .stall(stall), .resume(resume), .op_valid(op_valid),
      .op_onehot(op_onehot), .operand(operand), .phase(phase), .halted(halted),
      .retired(retired)
   );

   opcode_sequencer #(.CNTW(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(s_ready),
      .instr(instr), .stall(stall), .resume(resume), .op_valid(s_op_valid),
      .op_onehot(s_onehot), .operand(s_operand), .phase(s_phase), .halted(s_halted),
      .retired(s_retired)
   );

   int n_pass = 0, n_total = 0, n_fail = 0;
   bit chk_en = 1'b0;

   // Reference model: phases left on the current instruction, plus a halted flag.
   logic [15:0] multi_mask = 16'h0006;
   int          m_rem = 0;
   logic [3:0]  m_op = '0, m_opr = '0;
   bit          m_halted = 1'b0;
   int          m_ret = 0;

   function automatic int nphases(input logic [3:0] op);
      if (op == 4'd15) return 1;
      return multi_mask[op] ? 2 : 1;
   endfunction

   function automatic bit m_ready();
      if (!rst_n || m_halted) return 1'b0;
      if (m_rem == 0) return 1'b1;
      return !stall && m_rem == 1 && m_op != 4'd15;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [15:0] e_oh;
      e_oh = (m_rem > 0) ? (16'd1 << m_op) : 16'd0;
      chk("instr_ready", {31'd0, instr_ready}, {31'd0, m_ready()});
      chk("op_valid", {31'd0, op_valid}, {31'd0, m_rem > 0});
      chk("op_onehot", {16'd0, op_onehot}, {16'd0, e_oh});
      chk("operand", {28'd0, operand}, {28'd0, m_opr});
      chk("phase", {31'd0, phase}, {31'd0, (m_rem == 1 && nphases(m_op) == 2)});
      chk("halted", {31'd0, halted}, {31'd0, m_halted});
      chk("retired", {16'd0, retired}, (m_ret > 65535) ? 32'd65535 : m_ret);
      chk("retired_sat", {30'd0, s_retired}, (m_ret > 3) ? 32'd3 : m_ret);
   endtask

   task automatic model_edge();
      bit acc;
      acc = instr_valid && m_ready();
      if (!rst_n) begin
         m_rem = 0; m_op = '0; m_opr = '0; m_halted = 1'b0; m_ret = 0;
         chk_en = 1'b1;
      end else if (m_halted) begin
         if (resume) m_halted = 1'b0;
      end else begin
         if (m_rem > 0 && !stall) begin
            m_rem--;
            if (m_rem == 0) begin
               m_ret++;
               if (m_op == 4'd15) m_halted = 1'b1;
            end
         end
         if (acc) begin
            m_op  = instr[7:4];
            m_opr = instr[3:0];
            m_rem = nphases(instr[7:4]);
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      if (chk_en) check_all();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] ins, input logic st);
      instr_valid = v; instr = ins; stall = st;
   endtask

   initial begin
      rst_n = 1'b0; instr_valid = 1'b1; instr = 8'h35; stall = 1'b0; resume = 1'b0;
      // Reset with valid asserted
      step(); step();
      chk("rst_onehot", {16'd0, op_onehot}, 32'd0);
      rst_n = 1'b1;
      // Back-to-back single-phase ops
      drive(1'b1, 8'h35, 1'b0); step();
      chk("b2b_oh0", {16'd0, op_onehot}, 32'h0008);
      drive(1'b1, 8'hC2, 1'b0); step();
      chk("b2b_oh1", {16'd0, op_onehot}, 32'h1000);
      drive(1'b1, 8'hE7, 1'b0); step();
      chk("b2b_oh2", {16'd0, op_onehot}, 32'h4000);
      chk("b2b_opr2", {28'd0, operand}, 32'd7);
      drive(1'b0, 8'h00, 1'b0); step();
      chk("b2b_ret", {16'd0, retired}, 32'd3);
      // Two-phase LD
      drive(1'b1, 8'h1A, 1'b0); step();
      chk("ld_ph0", {31'd0, phase}, 32'd0);
      drive(1'b0, 8'h00, 1'b0); step();
      chk("ld_ph1", {31'd0, phase}, 32'd1);
      chk("ld_oh1", {16'd0, op_onehot}, 32'h0002);
      step();
      chk("ld_ret", {16'd0, retired}, 32'd4);
      // ST with stalls in both phases
      drive(1'b1, 8'h23, 1'b0); step();
      drive(1'b0, 8'h00, 1'b1); step(); step(); step();
      stall = 1'b0; step();
      stall = 1'b1; step(); step(); step();
      stall = 1'b0; step();
      chk("st_ret", {16'd0, retired}, 32'd5);
      // HALT, blocked input, resume
      drive(1'b1, 8'hF0, 1'b0); step();
      chk("halt_oh", {16'd0, op_onehot}, 32'h8000);
      drive(1'b0, 8'h00, 1'b0); step();
      chk("halt_flag", {31'd0, halted}, 32'd1);
      drive(1'b1, 8'h35, 1'b0);
      repeat (5) step();
      resume = 1'b1; step();
      resume = 1'b0;
      chk("resume_idle", {31'd0, halted}, 32'd0);
      step();
      chk("resume_acc", {16'd0, op_onehot}, 32'h0008);
      drive(1'b0, 8'h00, 1'b0); step();
      // NOOP saturation on the CNTW=2 instance
      rst_n = 1'b0; step(); rst_n = 1'b1;
      drive(1'b1, 8'h00, 1'b0);
      repeat (5) step();
      drive(1'b0, 8'h00, 1'b0); step();
      chk("sat_small", {30'd0, s_retired}, 32'd3);
      chk("sat_main", {16'd0, retired}, 32'd5);
      // Random traffic
      for (int i = 0; i < 400; i++) begin
         rst_n       = ($urandom_range(0, 49) != 0);
         instr_valid = $urandom_range(0, 2) != 0;
         case ($urandom_range(0, 5))
            0:       instr = {4'hF, 4'($urandom)};
            1:       instr = {4'($urandom_range(1, 2)), 4'($urandom)};
            default: instr = 8'($urandom);
         endcase
         stall  = ($urandom_range(0, 3) == 0);
         resume = ($urandom_range(0, 3) == 0);
         step();
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
